// File: rtl/alarm_set_ctrl.sv
// Front-panel controller for top_alarm: debounces three push-buttons and runs a
// RUN / SET_TIME / SET_ALARM editor that loads the clock time or commits the alarm time.
module alarm_set_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       btn_mode_i,
   input  logic       btn_next_i,
   input  logic       btn_up_i,
   input  logic [3:0] hourdec_now,
   input  logic [3:0] hourone_now,
   input  logic [3:0] mindec_now,
   input  logic [3:0] minone_now,
   input  logic       bud_state_i,
   output logic [3:0] hourdec_init,
   output logic [3:0] hourone_init,
   output logic [3:0] mindec_init,
   output logic [3:0] minone_init,
   output logic       time_load_o,
   output logic [3:0] hourdec_bud,
   output logic [3:0] hourone_bud,
   output logic [3:0] mindec_bud,
   output logic [3:0] minone_bud,
   output logic       bud_en,
   output logic       silence_o,
   output logic       edit_active_o,
   output logic [1:0] edit_digit_o
);

   localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CntMax = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {StRun, StSetTime, StSetAlarm} state_e;

   // Bit 2 = mode, bit 1 = next, bit 0 = up.
   logic [2:0]    raw;
   logic [2:0]    sync1_q, sync2_q, level_q, level_dly_q, press_q;
   logic [CW-1:0] cnt_q [3];
   logic          mode_p, next_p, up_p;

   state_e     state_q;
   logic [1:0] digit_q;
   logic [3:0] ed_hd_q, ed_ho_q, ed_md_q, ed_mo_q;
   logic [3:0] inc_hd, inc_ho, inc_md, inc_mo;

   assign raw = {btn_mode_i, btn_next_i, btn_up_i};

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         level_q     <= '0;
         level_dly_q <= '0;
         press_q     <= '0;
         for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      end else begin
         sync1_q     <= raw;
         sync2_q     <= sync1_q;
         level_dly_q <= level_q;
         press_q     <= level_q & ~level_dly_q;
         for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] != level_q[i]) begin
               if (cnt_q[i] == CntMax) begin
                  level_q[i] <= sync2_q[i];
                  cnt_q[i]   <= '0;
               end else begin
                  cnt_q[i] <= cnt_q[i] + 1'b1;
               end
            end else begin
               cnt_q[i] <= '0;
            end
         end
      end
   end

   assign mode_p = press_q[2];
   assign next_p = press_q[1] & ~press_q[2];
   assign up_p   = press_q[0] & ~(|press_q[2:1]);

   // Next value of the selected digit, keeping the edit register a valid 24 h time.
   always_comb begin
      inc_hd = ed_hd_q;
      inc_ho = ed_ho_q;
      inc_md = ed_md_q;
      inc_mo = ed_mo_q;
      case (digit_q)
         2'd0: begin
            inc_hd = (ed_hd_q >= 4'd2) ? 4'd0 : ed_hd_q + 4'd1;
            if (inc_hd == 4'd2 && ed_ho_q > 4'd3) inc_ho = 4'd3;
         end
         2'd1: inc_ho = ((ed_hd_q == 4'd2 && ed_ho_q >= 4'd3) || ed_ho_q >= 4'd9) ?
                        4'd0 : ed_ho_q + 4'd1;
         2'd2: inc_md = (ed_md_q >= 4'd5) ? 4'd0 : ed_md_q + 4'd1;
         default: inc_mo = (ed_mo_q >= 4'd9) ? 4'd0 : ed_mo_q + 4'd1;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= StRun;
         digit_q      <= 2'd0;
         ed_hd_q      <= '0;
         ed_ho_q      <= '0;
         ed_md_q      <= '0;
         ed_mo_q      <= '0;
         hourdec_init <= '0;
         hourone_init <= '0;
         mindec_init  <= '0;
         minone_init  <= '0;
         hourdec_bud  <= '0;
         hourone_bud  <= '0;
         mindec_bud   <= '0;
         minone_bud   <= '0;
         time_load_o  <= 1'b0;
         bud_en       <= 1'b0;
         silence_o    <= 1'b0;
      end else begin
         time_load_o <= 1'b0;
         // Mute only while ringing and enabled; the up press never toggles bud_en here.
         silence_o <= (silence_o || (state_q == StRun && up_p && bud_state_i)) &&
                      bud_state_i && bud_en;
         case (state_q)
            StRun: begin
               if (mode_p) begin
                  state_q <= StSetTime;
                  digit_q <= 2'd0;
                  ed_hd_q <= hourdec_now;
                  ed_ho_q <= hourone_now;
                  ed_md_q <= mindec_now;
                  ed_mo_q <= minone_now;
               end else if (up_p && !bud_state_i) begin
                  bud_en <= ~bud_en;
               end
            end
            StSetTime, StSetAlarm: begin
               if (mode_p) begin
                  digit_q <= 2'd0;
                  if (state_q == StSetTime) begin
                     state_q <= StSetAlarm;
                     ed_hd_q <= hourdec_bud;
                     ed_ho_q <= hourone_bud;
                     ed_md_q <= mindec_bud;
                     ed_mo_q <= minone_bud;
                  end else begin
                     state_q <= StRun;
                  end
               end else if (next_p) begin
                  if (digit_q == 2'd3) begin
                     digit_q <= 2'd0;
                     state_q <= StRun;
                     if (state_q == StSetTime) begin
                        hourdec_init <= ed_hd_q;
                        hourone_init <= ed_ho_q;
                        mindec_init  <= ed_md_q;
                        minone_init  <= ed_mo_q;
                        time_load_o  <= 1'b1;
                     end else begin
                        hourdec_bud <= ed_hd_q;
                        hourone_bud <= ed_ho_q;
                        mindec_bud  <= ed_md_q;
                        minone_bud  <= ed_mo_q;
                     end
                  end else begin
                     digit_q <= digit_q + 2'd1;
                  end
               end else if (up_p) begin
                  ed_hd_q <= inc_hd;
                  ed_ho_q <= inc_ho;
                  ed_md_q <= inc_md;
                  ed_mo_q <= inc_mo;
               end
            end
            default: begin
               state_q <= StRun;
               digit_q <= 2'd0;
            end
         endcase
      end
   end

   assign edit_active_o = (state_q != StRun);
   assign edit_digit_o  = digit_q;

endmodule

// File: tb/tb_alarm_set_ctrl.sv
// Bench for alarm_set_ctrl: a press-level behavioural model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_alarm_set_ctrl;

   localparam int unsigned N = 4;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       b_mode = 1'b0, b_next = 1'b0, b_up = 1'b0;
   logic [3:0] now_hd = 4'd1, now_ho = 4'd3, now_md = 4'd4, now_mo = 4'd7;
   logic       bud_state = 1'b0;
   logic [3:0] init_hd, init_ho, init_md, init_mo;
   logic [3:0] bud_hd, bud_ho, bud_md, bud_mo;
   logic       time_load, bud_en, silence, edit_active;
   logic [1:0] edit_digit;

   alarm_set_ctrl #(.DEBOUNCE_CYCLES(N)) dut (
      .clk(clk), .rstn(rstn),
      .btn_mode_i(b_mode), .btn_next_i(b_next), .btn_up_i(b_up),
      .hourdec_now(now_hd), .hourone_now(now_ho), .mindec_now(now_md), .minone_now(now_mo),
      .bud_state_i(bud_state),
      .hourdec_init(init_hd), .hourone_init(init_ho), .mindec_init(init_md),
      .minone_init(init_mo), .time_load_o(time_load),
      .hourdec_bud(bud_hd), .hourone_bud(bud_ho), .mindec_bud(bud_md), .minone_bud(bud_mo),
      .bud_en(bud_en), .silence_o(silence),
      .edit_active_o(edit_active), .edit_digit_o(edit_digit)
   );

   always #5 clk = ~clk;

   int vectors = 0, miscompares = 0, loads = 0;
   bit chk_en = 1'b0;

   // Model: mode 0=RUN 1=SET_TIME 2=SET_ALARM; digits index 0=hourdec .. 3=minone.
   int m_state, m_digit;
   int m_ed[4], m_init[4], m_bud[4];
   bit m_bud_en, m_sil, m_load;
   bit [2:0]   m_acc;
   bit [N-1:0] m_hist[3];
   bit [2:0]   m_dly[4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] pack4(input int a, input int b, input int c, input int d);
      return {a[3:0], b[3:0], c[3:0], d[3:0]};
   endfunction

   function automatic int digit_max(input int d);
      case (d)
         0: return 2;
         1: return (m_ed[0] == 2) ? 3 : 9;
         2: return 5;
         default: return 9;
      endcase
   endfunction

   task automatic model_reset();
      m_state = 0; m_digit = 0;
      for (int i = 0; i < 4; i++) begin
         m_ed[i] = 0; m_init[i] = 0; m_bud[i] = 0; m_dly[i] = '0;
      end
      m_bud_en = 0; m_sil = 0; m_load = 0; m_acc = '0;
      for (int b = 0; b < 3; b++) m_hist[b] = '0;
   endtask

   task automatic model_step();
      bit [2:0] raw, ev, ap;
      int now[4];
      raw = {b_mode, b_next, b_up};
      now[0] = int'(now_hd); now[1] = int'(now_ho); now[2] = int'(now_md); now[3] = int'(now_mo);
      // A level is accepted after N consecutive raw samples disagree with it; the press
      // reaches the editor a fixed four edges later (sync, accept, pulse, act).
      ev = '0;
      for (int b = 0; b < 3; b++) begin
         m_hist[b] = {m_hist[b][N-2:0], raw[b]};
         if (m_hist[b] == {N{~m_acc[b]}}) begin
            m_acc[b] = raw[b];
            ev[b] = raw[b];
         end
      end
      ap = m_dly[3];
      m_dly[3] = m_dly[2]; m_dly[2] = m_dly[1]; m_dly[1] = m_dly[0]; m_dly[0] = ev;
      m_load = 0;
      if (m_state == 0) begin
         if (ap[2]) begin
            m_state = 1; m_digit = 0;
            for (int i = 0; i < 4; i++) m_ed[i] = now[i];
         end else if (ap[0] && !ap[1]) begin
            if (bud_state) m_sil = 1;
            else m_bud_en = !m_bud_en;
         end
      end else if (ap[2]) begin
         m_digit = 0;
         if (m_state == 1) begin
            m_state = 2;
            for (int i = 0; i < 4; i++) m_ed[i] = m_bud[i];
         end else begin
            m_state = 0;
         end
      end else if (ap[1]) begin
         if (m_digit == 3) begin
            for (int i = 0; i < 4; i++) begin
               if (m_state == 1) m_init[i] = m_ed[i];
               else m_bud[i] = m_ed[i];
            end
            m_load = (m_state == 1);
            m_state = 0; m_digit = 0;
         end else begin
            m_digit++;
         end
      end else if (ap[0]) begin
         if (m_ed[m_digit] >= digit_max(m_digit)) m_ed[m_digit] = 0;
         else m_ed[m_digit]++;
         if (m_digit == 0 && m_ed[0] == 2 && m_ed[1] > 3) m_ed[1] = 3;
      end
      if (!bud_state || !m_bud_en) m_sil = 0;
   endtask

   always @(posedge clk or negedge rstn) begin
      if (!rstn) model_reset();
      else model_step();
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("init", 32'(pack4(init_hd, init_ho, init_md, init_mo)),
               32'(pack4(m_init[0], m_init[1], m_init[2], m_init[3])));
         check("bud", 32'(pack4(bud_hd, bud_ho, bud_md, bud_mo)),
               32'(pack4(m_bud[0], m_bud[1], m_bud[2], m_bud[3])));
         check("ctl", 32'({time_load, bud_en, silence, edit_active, edit_digit}),
               32'({m_load, m_bud_en, m_sil, m_state != 0, 2'(m_digit)}));
         if (time_load) loads++;
      end
   end

   task automatic press(input logic [2:0] b);
      @(negedge clk);
      {b_mode, b_next, b_up} = b;
      repeat (N + 2) @(negedge clk);
      {b_mode, b_next, b_up} = 3'b000;
      repeat (N + 8) @(negedge clk);
   endtask

   task automatic press_n(input logic [2:0] b, input int n);
      for (int i = 0; i < n; i++) press(b);
   endtask

   localparam logic [2:0] Mode = 3'b100, Next = 3'b010, Up = 3'b001;

   initial begin
      #100000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end

   initial begin
      int cyc, l0;
      bit found;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      check("reset_init", 32'(pack4(init_hd, init_ho, init_md, init_mo)), 32'h0);
      check("reset_ctl", 32'({time_load, bud_en, silence, edit_active, edit_digit}), 32'h0);
      @(negedge clk);
      rstn = 1'b1;
      repeat (4) @(negedge clk);

      // 1: short glitch ignored; bounce then stable press acts N+4 edges after the edge.
      b_mode = 1'b1;
      repeat (3) @(negedge clk);
      b_mode = 1'b0;
      repeat (12) @(negedge clk);
      check("t1_short", 32'(edit_active), 32'h0);
      b_mode = 1'b1;
      @(negedge clk) b_mode = 1'b0;
      @(negedge clk) b_mode = 1'b1;
      cyc = 0; found = 0;
      fork
         begin
            repeat (6) @(negedge clk);
            b_mode = 1'b0;
         end
         begin
            while (!found && cyc < 20) begin
               @(posedge clk);
               #1;
               cyc++;
               if (edit_active) found = 1;
            end
         end
      join
      check("t1_latency", 32'(cyc), 32'd8);
      repeat (12) @(negedge clk);
      press_n(Mode, 2);
      check("t1_run", 32'(edit_active), 32'h0);

      // 2: 13:47 -> 23:48 via hourdec and minone.
      l0 = loads;
      press(Mode); press(Up); press_n(Next, 3); press(Up); press(Next);
      check("t2_init", 32'(pack4(init_hd, init_ho, init_md, init_mo)), 32'h2348);
      check("t2_loads", 32'(loads - l0), 32'd1);
      check("t2_run", 32'(edit_active), 32'h0);

      // 2b: 18:59, hourdec x3 clamps hourone on stepping to 2, then each digit wraps.
      now_hd = 4'd1; now_ho = 4'd8; now_md = 4'd5; now_mo = 4'd9;
      press(Mode); press_n(Up, 3);
      press(Next); press(Up); press(Next); press(Up); press(Next); press(Up); press(Next);
      check("t2b_init", 32'(pack4(init_hd, init_ho, init_md, init_mo)), 32'h1400);

      // 2c: 22:00, hourone wraps 3 -> 0 under hourdec 2.
      now_hd = 4'd2; now_ho = 4'd2; now_md = 4'd0; now_mo = 4'd0;
      l0 = loads;
      press(Mode); press(Next); press_n(Up, 2); press_n(Next, 3);
      check("t2c_init", 32'(pack4(init_hd, init_ho, init_md, init_mo)), 32'h2000);
      check("t2c_loads", 32'(loads - l0), 32'd1);

      // 3: alarm edit to 06:30, no load; abandon keeps it.
      l0 = loads;
      press_n(Mode, 2);
      check("t3_edit", 32'({edit_active, edit_digit}), 32'b100);
      press(Next); press_n(Up, 6); press(Next); press_n(Up, 3); press_n(Next, 2);
      check("t3_bud", 32'(pack4(bud_hd, bud_ho, bud_md, bud_mo)), 32'h0630);
      check("t3_noload", 32'(loads - l0), 32'd0);
      check("t3_init", 32'(pack4(init_hd, init_ho, init_md, init_mo)), 32'h2000);
      press_n(Mode, 3);
      check("t3_keep", 32'(pack4(bud_hd, bud_ho, bud_md, bud_mo)), 32'h0630);
      check("t3_run", 32'(edit_active), 32'h0);

      // 4: enable, silence while ringing, silence drops with the ring.
      press(Up);
      check("t4_en", 32'(bud_en), 32'h1);
      @(negedge clk) bud_state = 1'b1;
      press(Up);
      check("t4_sil", 32'({bud_en, silence}), 32'b11);
      @(negedge clk) bud_state = 1'b0;
      @(posedge clk);
      #1;
      check("t4_unsil", 32'(silence), 32'h0);

      // 5: mode and up together: mode wins, bud_en untouched.
      press(Mode | Up);
      check("t5", 32'({edit_active, bud_en}), 32'b11);

      // 6: async reset at digit 2 clears everything and never loads.
      press_n(Next, 2);
      check("t6_digit", 32'(edit_digit), 32'd2);
      @(posedge clk);
      #2 rstn = 1'b0;
      #1;
      check("t6_ctl", 32'({time_load, bud_en, silence, edit_active, edit_digit}), 32'h0);
      check("t6_vals", 32'({pack4(init_hd, init_ho, init_md, init_mo),
                            pack4(bud_hd, bud_ho, bud_md, bud_mo)}), 32'h0);
      @(negedge clk) rstn = 1'b1;
      l0 = loads;
      repeat (20) @(negedge clk);
      check("t6_noload", 32'(loads - l0), 32'd0);
      check("t6_run", 32'(edit_active), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
